huff_stream_ctrl: RTL

//  Sequences the Huffman decoder core for a complete block of symbols.
//  - Accepts a packed, MSB-first bitstream as WORD_W-bit words.
//  - Keeps a bit buffer and presents the MAX_CODE_LEN-bit window to the core.
//  - Issues one decode request per symbol, then retires dec_len bits.
//  - Hands each symbol downstream on a valid/ready port; stops after nsym symbols.

---
 rtl/huff_pkg.sv | 28 ++
 rtl/huff_bitbuf.sv | 65 ++++++
 rtl/huff_stream_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
//------------------------------------------------------------------------------
// huff_pkg
// Shared widths and controller state encoding for the Huffman stream block.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package huff_pkg;

    localparam int MAX_CODE_LEN = 10;
    localparam int LEN_W        = 4;
    localparam int SYM_W        = 4;

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_CODE_LEN);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/huff_bitbuf.sv
//------------------------------------------------------------------------------
// huff_bitbuf
// MSB-first bit buffer: left shift retires bits, appends land below valid data.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module huff_bitbuf
    import huff_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int FILL_W = $clog2(2*WORD_W+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic [LEN_W-1:0]        shift_i,
    input  logic                    app_en_i,
    input  logic [WORD_W-1:0]       app_data_i,
    output logic [FILL_W-1:0]       fill_o,
    output logic [MAX_CODE_LEN-1:0] win_o
);

    localparam int                BUF_W     = 2*WORD_W;
    localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(WORD_W);

    logic [BUF_W-1:0]  bits_q, bits_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0]  w_shifted;
    logic [BUF_W-1:0]  w_app;
    logic [FILL_W-1:0] w_fill_sh;

    // Bits below fill are always zero, so OR-ing the aligned word is an append.
    always_comb begin
        w_shifted = bits_q << shift_i;
        w_fill_sh = fill_q - {{(FILL_W-LEN_W){1'b0}}, shift_i};
        w_app     = {app_data_i, {WORD_W{1'b0}}} >> w_fill_sh;
        bits_d    = w_shifted;
        fill_d    = w_fill_sh;
        if (app_en_i) begin
            bits_d = w_shifted | w_app;
            fill_d = w_fill_sh + FILL_WORD;
        end
        if (clear_i) begin
            bits_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
        end
    end

    assign fill_o = fill_q;
    assign win_o  = bits_q[BUF_W-1 -: MAX_CODE_LEN];

endmodule

`default_nettype wire

// File: rtl/huff_stream_ctrl.sv
//------------------------------------------------------------------------------
// huff_stream_ctrl
// Sequences the Huffman decoder core over a block of nsym symbols.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module huff_stream_ctrl
    import huff_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        nsym_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic [WORD_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    output logic                    in_ready_o,
    output logic [MAX_CODE_LEN-1:0] win_o,
    output logic                    dec_req_o,
    input  logic                    dec_done_i,
    input  logic [LEN_W-1:0]        dec_len_i,
    input  logic [SYM_W-1:0]        dec_sym_i,
    output logic [SYM_W-1:0]        sym_out_o,
    output logic                    sym_valid_o,
    input  logic                    sym_ready_i
);

    localparam int                BUF_W     = 2*WORD_W;
    localparam int                FILL_W    = $clog2(BUF_W+1);
    localparam logic [FILL_W-1:0] FILL_CODE = FILL_W'(MAX_CODE_LEN);
    localparam logic [FILL_W-1:0] FILL_ROOM = FILL_W'(BUF_W-WORD_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  nsym_q, nsym_d;
    logic              last_q, last_d;
    logic [SYM_W-1:0]  sym_q, sym_d;

    logic [FILL_W-1:0] w_fill;
    logic              w_clear;
    logic              w_shift_en;
    logic              w_app_en;
    logic [LEN_W-1:0]  w_shift_len;
    logic              w_len_bad;

    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);
    assign dec_req_o   = (state_q == ST_REQ);
    assign sym_valid_o = (state_q == ST_EMIT);
    assign sym_out_o   = sym_q;
    assign in_ready_o  = busy_o && !last_q && (w_fill <= FILL_ROOM);
    assign w_app_en    = in_valid_i && in_ready_o;
    assign w_shift_len = w_shift_en ? dec_len_i : '0;
    assign w_len_bad   = (dec_len_i == '0) || (dec_len_i > C_MAX_LEN) ||
                         ({{(FILL_W-LEN_W){1'b0}}, dec_len_i} > w_fill);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nsym_d     = nsym_q;
        last_d     = last_q;
        sym_d      = sym_q;
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        if (w_app_en && in_last_i) begin
            last_d = 1'b1;
        end
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_i) begin
                    w_clear = 1'b1;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    nsym_d  = nsym_i;
                    state_d = (nsym_i == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                // Once the stream has ended, a partial window is decoded as-is.
                if ((w_fill >= FILL_CODE) || (last_q && (w_fill != '0))) begin
                    state_d = ST_REQ;
                end else if (last_q) begin
                    state_d = ST_ERR;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dec_done_i) begin
                    if (w_len_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        w_shift_en = 1'b1;
                        sym_d      = dec_sym_i;
                        cnt_d      = cnt_q + 1'b1;
                        state_d    = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (sym_ready_i) begin
                    state_d = (cnt_q == nsym_q) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nsym_q  <= '0;
            last_q  <= 1'b0;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nsym_q  <= nsym_d;
            last_q  <= last_d;
            sym_q   <= sym_d;
        end
    end

    huff_bitbuf #(
        .WORD_W (WORD_W),
        .FILL_W (FILL_W)
    ) u_bitbuf (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (w_clear),
        .shift_i    (w_shift_len),
        .app_en_i   (w_app_en),
        .app_data_i (in_data_i),
        .fill_o     (w_fill),
        .win_o      (win_o)
    );

endmodule

`default_nettype wire
